led_tick_divider: RTL and testbench

- Synchronous, parametrised clock-enable generator with CHANNELS independent channels.
- Each channel has a runtime-programmable divisor, a periodic or one-shot mode, a one-cycle tick output and a toggling wave output.
- It drives LED blink rates and irrigation timing strobes from the single system clock. No derived clocks; all logic runs on clk.

---
 rtl/led_tick_divider.sv | 53 +++++
 tb/tb_led_tick_divider.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/led_tick_divider.sv
// led_tick_divider: per-channel programmable clock-enable ticks with square wave and one-shot done flag.
module led_tick_divider #(
    parameter int          CHANNELS    = 4,
    parameter int          WIDTH       = 26,
    parameter int unsigned DEFAULT_DIV = 49999999,
    parameter int          CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [CH_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                load_mode,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] wave,
    output logic [CHANNELS-1:0] done
);
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
    for (genvar g = 0; g < CHANNELS; g++) begin : ch
        logic [WIDTH-1:0] cnt, div;
        logic mode, t, w, dn;
        logic wrap;
        assign wrap = cnt == div;
        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt  <= '0;
                div  <= DEF;
                mode <= 1'b0;
                t    <= 1'b0;
                w    <= 1'b0;
                dn   <= 1'b0;
            end else if (load && load_ch == CH_W'(g)) begin
                cnt  <= '0;
                div  <= load_val;
                mode <= load_mode;
                t    <= 1'b0;
                w    <= 1'b0;
                dn   <= 1'b0;
            end else if (enable && div != '0 && !dn) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                t   <= wrap;
                w   <= w ^ wrap;
                dn  <= mode && wrap;
            end else begin
                t <= 1'b0;
            end
        end
        assign tick[g] = t;
        assign wave[g] = w;
        assign done[g] = dn;
    end
endmodule

// File: tb/tb_led_tick_divider.sv
// tb_led_tick_divider: directed self-checking bench for led_tick_divider (3 channels, 4-bit divisors).
module tb_led_tick_divider;
    localparam int CHANNELS = 3;
    localparam int WIDTH    = 4;
    localparam int CH_W     = 2;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic load = 1'b0;
    logic load_mode = 1'b0;
    logic [CH_W-1:0] load_ch = '0;
    logic [WIDTH-1:0] load_val = '0;
    logic [CHANNELS-1:0] tick, wave, done;
    logic [2:0] e;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    led_tick_divider #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .load_ch(load_ch),
        .load_val(load_val), .load_mode(load_mode), .tick(tick), .wave(wave), .done(done)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic ld(input int c, input int val, input logic m);
        load      = 1'b1;
        load_ch   = CH_W'(c);
        load_val  = WIDTH'(val);
        load_mode = m;
        step();
        load = 1'b0;
    endtask

    initial begin
        // reset defaults, then free run with D=3
        step(2);
        chk("rst tick", tick, 3'b000);
        chk("rst wave", wave, 3'b000);
        chk("rst done", done, 3'b000);
        reset = 1'b1;
        enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("def tick", tick, (k % 4 == 0) ? 3'b111 : 3'b000);
            chk("def wave", wave, ((k / 4) % 2 == 1) ? 3'b111 : 3'b000);
            chk("def done", done, 3'b000);
        end
        // independent loads: ch1 D=1, ch2 D=4, ch0 keeps D=3 phase
        ld(1, 1, 1'b0);
        chk("ld1 tick", tick, 3'b000);
        chk("ld1 wave", wave, 3'b101);
        ld(2, 4, 1'b0);
        chk("ld2 tick", tick, 3'b000);
        chk("ld2 wave", wave, 3'b001);
        for (int j = 1; j <= 20; j++) begin
            step();
            e[0] = (j % 4 == 2);
            e[1] = (j % 2 == 1);
            e[2] = (j % 5 == 0);
            chk("indep tick", tick, e);
        end
        chk("indep wave", wave, 3'b000);
        chk("indep done", done, 3'b000);
        // one-shot on ch0
        reset = 1'b0;
        step();
        reset = 1'b1;
        ld(0, 2, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("os tick", tick & 3'b001, (k == 3) ? 3'b001 : 3'b000);
        end
        chk("os done", done, 3'b001);
        chk("os wave", wave & 3'b001, 3'b001);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("os quiet", tick & 3'b001, 3'b000);
        end
        chk("os done hold", done, 3'b001);
        chk("os wave hold", wave & 3'b001, 3'b001);
        ld(0, 2, 1'b0);
        chk("reld done", done, 3'b000);
        chk("reld tick", tick & 3'b001, 3'b000);
        chk("reld wave", wave & 3'b001, 3'b000);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("reld per", tick & 3'b001, (k % 3 == 0) ? 3'b001 : 3'b000);
        end
        // enable pause at cnt=2 with wave high
        reset = 1'b0;
        step();
        reset = 1'b1;
        step(6);
        chk("pre pause tick", tick, 3'b000);
        chk("pre pause wave", wave, 3'b111);
        enable = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("pause tick", tick, 3'b000);
            chk("pause wave", wave, 3'b111);
        end
        enable = 1'b1;
        step();
        chk("resume1 tick", tick, 3'b000);
        step();
        chk("resume2 tick", tick, 3'b111);
        chk("resume2 wave", wave, 3'b000);
        // D=0 halts ch2
        ld(2, 0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("halt tick", tick & 3'b100, 3'b000);
        end
        chk("halt wave", wave & 3'b100, 3'b000);
        chk("halt done", done, 3'b000);
        // load on the wrap edge of ch1
        reset = 1'b0;
        step();
        reset = 1'b1;
        step(3);
        chk("pre wrap tick", tick, 3'b000);
        ld(1, 2, 1'b0);
        chk("wrap ld tick", tick, 3'b101);
        chk("wrap ld wave", wave, 3'b101);
        step();
        chk("wrap e5", tick, 3'b000);
        step();
        chk("wrap e6", tick, 3'b000);
        step();
        chk("wrap e7", tick, 3'b010);
        chk("wrap e7 wave", wave, 3'b111);
        step();
        chk("wrap e8", tick, 3'b101);
        chk("wrap e8 wave", wave, 3'b010);
        // out-of-range channel select is ignored
        ld(3, 0, 1'b1);
        chk("bad ch tick", tick, 3'b000);
        chk("bad ch wave", wave, 3'b010);
        chk("bad ch done", done, 3'b000);
        step();
        chk("bad ch e10", tick, 3'b010);
        chk("bad ch e10 wave", wave, 3'b000);
        step();
        chk("bad ch e11", tick, 3'b000);
        step();
        chk("bad ch e12", tick, 3'b101);
        // reset beats a simultaneous load
        reset = 1'b0;
        load = 1'b1;
        load_ch = 2'd0;
        load_val = 4'd1;
        load_mode = 1'b1;
        step();
        load = 1'b0;
        reset = 1'b1;
        chk("rst+ld tick", tick, 3'b000);
        chk("rst+ld wave", wave, 3'b000);
        chk("rst+ld done", done, 3'b000);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("rst+ld run", tick, (k == 4) ? 3'b111 : 3'b000);
        end
        chk("rst+ld done2", done, 3'b000);
        // full-range divisor on ch2
        ld(2, 15, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("max tick", tick & 3'b100, (k % 16 == 0) ? 3'b100 : 3'b000);
            if (k == 16) chk("max wave16", wave & 3'b100, 3'b100);
        end
        chk("max wave32", wave & 3'b100, 3'b000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
